// File: rtl/branch_predictor_pkg.sv
// Shared branch predictor definitions: address width, 2-bit counter encodings
// and the PC index/tag slicing used by both the fetch and update paths.
package branch_predictor_pkg;
    localparam int ADDR_W = 40;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    localparam ctr_t CTR_RESET = WNT;
endpackage

`define BP_IDX(pc, IB) pc[(IB)+1:2]
`define BP_TAG(pc, IB, TB) pc[(IB)+(TB)+1:(IB)+2]

// File: rtl/bp_sat_counter.sv
// Next state of a 2-bit saturating direction counter given the resolved outcome.
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters plus tagged BTB; one-cycle registered
// prediction for fetch, trained by resolved branches from execute.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    input  logic              stall_i,
    input  logic [ADDR_W-1:0] pc_fetch_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    output logic [15:0]       mispredict_count_o
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ctr_t                ctr_q       [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid_q;
    logic [TAG_BITS-1:0] btb_tag_q   [ENTRIES];
    logic [ADDR_W-1:0]   btb_target_q[ENTRIES];

    logic                vld_p1;
    logic                pred_taken_p1;
    logic [ADDR_W-1:0]   pred_target_p1;
    logic [15:0]         miss_cnt_q;

    // Stage p0: table lookup for the fetch PC and update-path next state
    logic [INDEX_BITS-1:0] req_idx_p0;
    logic [TAG_BITS-1:0]   req_tag_p0;
    logic                  hit_taken_p0;
    logic [INDEX_BITS-1:0] upd_idx_p0;
    logic [TAG_BITS-1:0]   upd_tag_p0;
    ctr_t                  upd_ctr_nxt_p0;
    logic [ADDR_W-INDEX_BITS-TAG_BITS-1:0] unused_upd_pc;

    assign req_idx_p0    = `BP_IDX(pc_fetch_i, INDEX_BITS);
    assign req_tag_p0    = `BP_TAG(pc_fetch_i, INDEX_BITS, TAG_BITS);
    assign hit_taken_p0  = btb_valid_q[req_idx_p0] && (btb_tag_q[req_idx_p0] == req_tag_p0)
                           && ctr_q[req_idx_p0][1];
    assign upd_idx_p0    = `BP_IDX(upd_pc_i, INDEX_BITS);
    assign upd_tag_p0    = `BP_TAG(upd_pc_i, INDEX_BITS, TAG_BITS);
    assign unused_upd_pc = {upd_pc_i[ADDR_W-1:INDEX_BITS+TAG_BITS+2], upd_pc_i[1:0]};

    bp_sat_counter u_sat_counter (
        .cur   (ctr_q[upd_idx_p0]),
        .taken (upd_taken_i),
        .nxt   (upd_ctr_nxt_p0)
    );

    // Stage p1: registered prediction; table writes land after the read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1         <= 1'b0;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
            miss_cnt_q     <= '0;
            btb_valid_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            if (!stall_i) begin
                vld_p1 <= req_valid_i;
                if (req_valid_i) begin
                    pred_taken_p1  <= hit_taken_p0;
                    pred_target_p1 <= hit_taken_p0 ? btb_target_q[req_idx_p0]
                                                   : pc_fetch_i + ADDR_W'(4);
                end
            end
            if (upd_valid_i) begin
                ctr_q[upd_idx_p0] <= upd_ctr_nxt_p0;
                if (upd_taken_i) begin
                    btb_valid_q[upd_idx_p0] <= 1'b1;
                end
                if (upd_taken_i != ctr_q[upd_idx_p0][1]) begin
                    miss_cnt_q <= sat_inc16(miss_cnt_q);
                end
            end
        end
    end

    // BTB payload is qualified by btb_valid_q, so it carries no reset
    always_ff @(posedge clk_i) begin
        if (upd_valid_i && upd_taken_i) begin
            btb_tag_q[upd_idx_p0]    <= upd_tag_p0;
            btb_target_q[upd_idx_p0] <= upd_target_i;
        end
    end

    assign pred_valid_o       = vld_p1;
    assign pred_taken_o       = pred_taken_p1;
    assign pred_target_o      = pred_target_p1;
    assign mispredict_count_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        stall;
    logic [39:0] pc_fetch;
    logic        pred_valid;
    logic        pred_taken;
    logic [39:0] pred_target;
    logic        upd_valid;
    logic [39:0] upd_pc;
    logic        upd_taken;
    logic [39:0] upd_target;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ctr   [64];
    bit          m_valid [64];
    logic [7:0]  m_tag   [64];
    logic [39:0] m_tgt   [64];
    int          m_miss;
    logic        exp_vld;
    logic        exp_taken;
    logic [39:0] exp_target;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .req_valid_i        (req_valid),
        .stall_i            (stall),
        .pc_fetch_i         (pc_fetch),
        .pred_valid_o       (pred_valid),
        .pred_taken_o       (pred_taken),
        .pred_target_o      (pred_target),
        .upd_valid_i        (upd_valid),
        .upd_pc_i           (upd_pc),
        .upd_taken_i        (upd_taken),
        .upd_target_i       (upd_target),
        .mispredict_count_o (miss_cnt)
    );

    function automatic int idx_of(input logic [39:0] pc);
        return int'((pc >> 2) & 40'h3F);
    endfunction

    function automatic logic [7:0] tag_of(input logic [39:0] pc);
        return 8'((pc >> 8) & 40'hFF);
    endfunction

    // Applies one clock edge worth of behaviour to the model: prediction is
    // formed from the tables before the update modifies them.
    task automatic model_clock();
        int  i;
        bit  hit;
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                m_ctr[k]   = 1;
                m_valid[k] = 0;
            end
            m_miss     = 0;
            exp_vld    = 0;
            exp_taken  = 0;
            exp_target = 0;
        end else begin
            if (!stall) begin
                exp_vld = req_valid;
                if (req_valid) begin
                    i          = idx_of(pc_fetch);
                    hit        = m_valid[i] && (m_tag[i] == tag_of(pc_fetch));
                    exp_taken  = hit && (m_ctr[i] >= 2);
                    exp_target = exp_taken ? m_tgt[i] : pc_fetch + 40'd4;
                end
            end
            if (upd_valid) begin
                i = idx_of(upd_pc);
                if (upd_taken != (m_ctr[i] >= 2) && m_miss < 65535) m_miss++;
                if (upd_taken) begin
                    if (m_ctr[i] < 3) m_ctr[i]++;
                    m_valid[i] = 1;
                    m_tag[i]   = tag_of(upd_pc);
                    m_tgt[i]   = upd_target;
                end else if (m_ctr[i] > 0) begin
                    m_ctr[i]--;
                end
            end
        end
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; req_valid = 0; stall = 0; upd_valid = 0; upd_taken = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic train(input logic [39:0] pc, input logic tk, input logic [39:0] tgt);
        idle();
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        cycle();
        idle();
    endtask

    task automatic request(input logic [39:0] pc);
        idle();
        req_valid = 1; pc_fetch = pc;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pred_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %0b expected 0", pred_taken); end
        checks++; if (pred_target !== 40'h0) begin errors++; $display("FAIL reset_target: got %h expected 0", pred_target); end
        checks++; if (miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", miss_cnt); end
        request(40'h1000);
        checks++; if (pred_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %0b expected 1", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL first_req_taken: got %0b expected 0", pred_taken); end
        checks++; if (pred_target !== 40'h1004) begin errors++; $display("FAIL first_req_target: got %h expected 1004", pred_target); end
    endtask

    task automatic test_train();
        train(40'h1000, 1, 40'h2000);
        request(40'h1000);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_taken: got %0b expected 1", pred_taken); end
        checks++; if (pred_target !== 40'h2000) begin errors++; $display("FAIL train_target: got %h expected 2000", pred_target); end
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL train_miss: got %0d expected 1", miss_cnt); end
    endtask

    task automatic test_saturation();
        repeat (4) train(40'h1000, 1, 40'h2000);
        train(40'h1000, 0, 40'h0);
        request(40'h1000);
        checks++; if (pred_taken !== 1'b1 || pred_target !== 40'h2000) begin
            errors++; $display("FAIL sat_hi: got taken=%0b target=%h expected 1/2000", pred_taken, pred_target); end
        checks++; if (miss_cnt !== 16'(m_miss)) begin errors++; $display("FAIL sat_hi_miss: got %0d expected %0d", miss_cnt, m_miss); end
        repeat (3) train(40'h1000, 0, 40'h0);
        request(40'h1000);
        checks++; if (pred_taken !== 1'b0 || pred_target !== 40'h1004) begin
            errors++; $display("FAIL sat_lo: got taken=%0b target=%h expected 0/1004", pred_taken, pred_target); end
        train(40'h1000, 1, 40'h2000);
        request(40'h1000);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor: got %0b expected 0", pred_taken); end
        checks++; if (miss_cnt !== 16'(m_miss)) begin errors++; $display("FAIL sat_lo_miss: got %0d expected %0d", miss_cnt, m_miss); end
    endtask

    task automatic test_alias();
        do_reset();
        train(40'h1000, 1, 40'h2000);
        request(40'h1000 + (40'd1 << 8));
        checks++; if (pred_taken !== 1'b0 || pred_target !== 40'h1104) begin
            errors++; $display("FAIL alias_tag: got taken=%0b target=%h expected 0/1104", pred_taken, pred_target); end
        request(40'hAB_0000_1003);
        checks++; if (pred_taken !== 1'b1 || pred_target !== 40'h2000) begin
            errors++; $display("FAIL alias_upper: got taken=%0b target=%h expected 1/2000", pred_taken, pred_target); end
        request(40'hFF_FFFF_FFFC);
        checks++; if (pred_taken !== 1'b0 || pred_target !== 40'h0) begin
            errors++; $display("FAIL wrap_target: got taken=%0b target=%h expected 0/0", pred_taken, pred_target); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        idle();
        req_valid = 1; pc_fetch = 40'h1000;
        upd_valid = 1; upd_pc = 40'h1000; upd_taken = 1; upd_target = 40'h2000;
        cycle();
        checks++; if (pred_taken !== 1'b0 || pred_target !== 40'h1004) begin
            errors++; $display("FAIL same_cycle_old: got taken=%0b target=%h expected 0/1004", pred_taken, pred_target); end
        request(40'h1000);
        checks++; if (pred_taken !== 1'b1 || pred_target !== 40'h2000) begin
            errors++; $display("FAIL same_cycle_new: got taken=%0b target=%h expected 1/2000", pred_taken, pred_target); end
    endtask

    task automatic test_stall_reset();
        train(40'h1000, 1, 40'h2000);
        request(40'h1000);
        for (int c = 0; c < 3; c++) begin
            idle();
            stall = 1; req_valid = 1; pc_fetch = 40'h5000;
            upd_valid = 1; upd_pc = 40'h1000; upd_taken = 0;
            cycle();
            checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 40'h2000) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%0b t=%0b tgt=%h expected 1/1/2000", c, pred_valid, pred_taken, pred_target); end
        end
        idle();
        stall = 1; rst = 1; req_valid = 1; pc_fetch = 40'h1000;
        cycle();
        checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 40'h0 || miss_cnt !== 16'h0) begin
            errors++; $display("FAIL stall_reset: got v=%0b t=%0b tgt=%h miss=%0d expected all 0", pred_valid, pred_taken, pred_target, miss_cnt); end
        request(40'h1000);
        checks++; if (pred_taken !== 1'b0 || pred_target !== 40'h1004) begin
            errors++; $display("FAIL post_reset: got taken=%0b target=%h expected 0/1004", pred_taken, pred_target); end
    endtask

    task automatic test_idle_hold();
        do_reset();
        train(40'h2040, 1, 40'h7777);
        train(40'h2040, 1, 40'h7777);
        request(40'h2040);
        idle();
        cycle();
        checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b1 || pred_target !== 40'h7777) begin
            errors++; $display("FAIL idle_hold: got v=%0b t=%0b tgt=%h expected 0/1/7777", pred_valid, pred_taken, pred_target); end
    endtask

    task automatic test_random();
        logic [39:0] pool [8];
        for (int k = 0; k < 8; k++) begin
            pool[k] = {22'h0, 8'(k % 2 + 1), 6'(k / 2), 2'b00};
        end
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            pc_fetch  = pool[$urandom_range(0, 7)] | {22'($urandom), 16'h0, 2'($urandom)};
            upd_valid = ($urandom_range(0, 2) != 0);
            upd_pc    = pool[$urandom_range(0, 7)] | {22'($urandom), 16'h0, 2'($urandom)};
            upd_taken = ($urandom_range(0, 2) != 0);
            upd_target = {8'($urandom), 32'($urandom)};
            cycle();
            checks++; if (pred_valid !== exp_vld) begin errors++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", c, pred_valid, exp_vld); end
            checks++; if (pred_taken !== exp_taken) begin errors++; $display("FAIL rand_taken[%0d]: got %0b expected %0b", c, pred_taken, exp_taken); end
            checks++; if (pred_target !== exp_target) begin errors++; $display("FAIL rand_target[%0d]: got %h expected %h", c, pred_target, exp_target); end
            checks++; if (miss_cnt !== 16'(m_miss)) begin errors++; $display("FAIL rand_miss[%0d]: got %0d expected %0d", c, miss_cnt, m_miss); end
        end
        idle();
    endtask

    initial begin
        idle();
        pc_fetch = 0; upd_pc = 0; upd_target = 0;
        @(negedge clk);
        test_reset();
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle();
        test_stall_reset();
        test_idle_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
